uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; the block supports 2..8.
REQ-002 Parameter DATA_W, default 8: width of one character.
REQ-003 Parameter TIMEOUT_CYC, default 200000: maximum clk cycles to wait for tx_done.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, as follows.
REQ-005 clk  input  1  system clock; every register updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  N_REQ  per-requester send request; held high until the matching gnt.
REQ-008 req_data  input  N_REQ*DATA_W  packed characters; slice i is [i*DATA_W +: DATA_W].
REQ-009 gnt  output  N_REQ  one-hot, one-cycle pulse; the character from requester i has been accepted.
REQ-010 start  output  1  one-cycle pulse to the UART transmitter.
REQ-011 tx_data  output  DATA_W  character to the UART; valid from start until the return to IDLE.
REQ-012 tx_done  input  1  UART frame-complete pulse.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  one-cycle pulse on a timeout.

Function
REQ-015 The FSM SHALL have three states: IDLE, START, WAIT_DONE.
REQ-016 IDLE with req != 0: select the winner by round-robin, latch its data into tx_data, go to START.
- Round-robin search starts at last_gnt+1 mod N_REQ and increases.
REQ-017 IDLE with req == 0: stay in IDLE; all outputs other than tx_data are held 0.
REQ-018 START lasts exactly one cycle.
- start=1 and gnt[winner]=1 in that cycle.
- last_gnt is updated to the winner.
- Next state is WAIT_DONE.
REQ-019 WAIT_DONE: on tx_done=1, return to IDLE on the next edge.
REQ-020 Back-to-back throughput: a new winner MAY be selected in the first IDLE cycle after WAIT_DONE.
- Minimum spacing between start pulses is therefore 3 cycles plus the UART frame time.
REQ-021 WAIT_DONE timeout counter:
- Cleared on entry to WAIT_DONE; counts cycles.
- When it reaches TIMEOUT_CYC-1 without tx_done: pulse err=1 for one cycle and go to IDLE.
- tx_done in that same cycle takes precedence; err stays 0.
REQ-022 tx_done is ignored in IDLE and in START.
REQ-023 Changes to req or req_data after the IDLE select cycle SHALL NOT alter tx_data or the winner.
REQ-024 A requester that drops req before its grant is not served; no gnt is issued for it.
REQ-025 Fairness: with all N_REQ requesters continuously requesting, grants are issued in strict rotation.
- Each requester gets exactly one grant per N_REQ grants.
REQ-026 last_gnt arithmetic wraps modulo N_REQ; its width is clog2(N_REQ).

Reset
REQ-027 While reset=1, on the clock edge:
- state=IDLE
- last_gnt=N_REQ-1, so requester 0 has first priority
- timeout counter=0
- start=0, gnt=0, busy=0, err=0, tx_data=0
REQ-028 Reset asserted in any state aborts the transaction.
- No gnt, start or err pulse is produced in the reset cycle or the cycle after it.
- A transaction in progress is not resumed.

Structure
REQ-029 The shared package uart_pkg SHALL hold:
- the state encoding (IDLE/START/WAIT_DONE)
- default N_REQ, DATA_W and TIMEOUT_CYC constants
REQ-030 The round-robin selection SHALL be a combinational sub-module rr_pick.
- Inputs: req and last_gnt.
- Outputs: valid and winner index.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 Single request: req=4'b0100, data slice 2=8'h41; tx_done returned 10 cycles after start.
- Required: start and gnt=4'b0100 in the same cycle, tx_data=8'h41.
- busy drops 1 cycle after tx_done.
REQ-033 All four request continuously, immediate tx_done each frame.
- Required: gnt order 0,1,2,3,0,1.
- No back-to-back grant to the same requester.
REQ-034 Timeout: TIMEOUT_CYC=16, req=4'b0001, tx_done never returned.
- Required: err pulses 16 cycles after entry to WAIT_DONE, then IDLE.
- On a later request from requester 1, gnt=4'b0010 follows.
REQ-035 Simultaneous events: tx_done and the timeout limit in the same cycle.
- Required: err=0 and a normal return to IDLE.
- Also: tx_done pulsed in IDLE produces no state change.
REQ-036 Reset mid-frame: reset for 1 cycle during WAIT_DONE with req=4'b0011 still high.
- Required: busy=0 and start=0 after reset.
- Next grant goes to requester 0.
REQ-037 Data stability: change req_data slice 1 from 8'h55 to 8'hAA one cycle after gnt=4'b0010.
- Required: tx_data stays 8'h55 until the return to IDLE.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default sizing.
package uart_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 200000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  // Index width for a requester number; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_gnt, wrapping mod N_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % N_REQ);
  endfunction

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    valid  = |req;
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[wrap_idx(last_gnt, k)]) begin
        winner = wrap_idx(last_gnt, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters, with done timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_done,
  output logic                    busy,
  output logic                    err
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_last_gnt;
  logic [IDX_W-1:0]   r_winner;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_tx_data;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_start;
  logic               r_busy;
  logic               r_err;

  state_t             w_state_nxt;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [DATA_W-1:0]  w_pick_data;
  logic               w_ld;
  logic               w_upd_last;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic               w_start_nxt;
  logic               w_busy_nxt;
  logic               w_err_nxt;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req     (req),
    .last_gnt(r_last_gnt),
    .valid   (w_pick_vld),
    .winner  (w_pick_idx)
  );

  assign w_pick_data = req_data[int'(w_pick_idx)*DATA_W +: DATA_W];

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_upd_last  = 1'b0;
    w_gnt_nxt   = '0;
    w_start_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt           = ST_START;
          w_ld                  = 1'b1;
          w_start_nxt           = 1'b1;
          w_gnt_nxt[w_pick_idx] = 1'b1;
        end
      end
      ST_START: begin
        w_state_nxt = ST_WAIT_DONE;
        w_upd_last  = 1'b1;
      end
      ST_WAIT_DONE: begin
        // A frame completing on the limit cycle wins over the timeout.
        if (tx_done) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs carry the value belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= IDX_W'(N_REQ - 1);
      r_winner   <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_gnt      <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_gnt   <= w_gnt_nxt;
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      if (w_ld) begin
        r_winner  <= w_pick_idx;
        r_tx_data <= w_pick_data;
      end
      if (w_upd_last) begin
        r_last_gnt <= r_winner;
      end
      if (r_state == ST_START) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT_DONE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign gnt     = r_gnt;
  assign start   = r_start;
  assign tx_data = r_tx_data;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: driver pushes predicted grants, monitor checks them.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            start;
  logic [DW-1:0]   tx_data;
  logic            tx_done;
  logic            busy;
  logic            err;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_last;

  uart_tx_arbiter #(
    .N_REQ(N),
    .DATA_W(DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .start(start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Reference arbitration: first requester after the last grant, counting upward mod N.
  function automatic int rr_model(input logic [N-1:0] m, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic push_exp(input int w);
    exp_t e;
    e.gnt = '0;
    e.gnt[w[1:0]] = 1'b1;
    e.data = req_data[w*DW +: DW];
    exp_q.push_back(e);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom());
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the START cycle.
  task automatic issue(input logic [N-1:0] mask, input logic [N*DW-1:0] data, output bit ok);
    int w;
    int waited;
    req_data = data;
    w = rr_model(mask, model_last);
    model_last = w;
    push_exp(w);
    req = mask;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!start && waited < 4);
    ok = start;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL start_wait: no start within %0d cycles, expected gnt %b", waited, mask);
      req = '0;
    end
  endtask

  // Starts at the START-cycle negedge; d >= TO means the UART never answers.
  task automatic finish(input int d, input bit done_in_start, input bit noise);
    req = noise ? N'($urandom()) : '0;
    rand_data();
    tx_done = done_in_start;
    if (d >= TO) begin
      err_q.push_back(1);
      for (int i = 0; i < TO; i++) begin
        @(negedge clk);
        tx_done = 1'b0;
        if (i == 10) req = '0;
      end
      check("busy_before_timeout", 32'(busy), 32'd1);
      @(negedge clk);
      check("err_at_timeout", 32'(err), 32'd1);
      check("busy_after_timeout", 32'(busy), 32'd0);
    end else begin
      for (int i = 0; i <= d; i++) begin
        @(negedge clk);
        tx_done = 1'b0;
      end
      check("busy_in_wait", 32'(busy), 32'd1);
      tx_done = 1'b1;
      req = '0;
      @(negedge clk);
      tx_done = 1'b0;
      check("busy_drop", 32'(busy), 32'd0);
      check("err_with_done", 32'(err), 32'd0);
    end
  endtask

  task automatic txn(input logic [N-1:0] mask, input logic [N*DW-1:0] data,
                     input int d, input bit dis, input bit noise);
    bit ok;
    issue(mask, data, ok);
    if (ok) finish(d, dis, noise);
  endtask

  // Monitor: every grant must match the head of the scoreboard; tx_data must hold while busy.
  logic [DW-1:0] held_data;
  bit in_tx = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (start || gnt != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: gnt=%b start=%b, expected none", gnt, start);
      end else begin
        e = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("start_with_gnt", 32'(start), 32'd1);
        check("tx_data", 32'(tx_data), 32'(e.data));
      end
      held_data = tx_data;
      in_tx = 1'b1;
    end else if (busy && in_tx) begin
      check("tx_data_hold", 32'(tx_data), 32'(held_data));
    end
    if (!busy) in_tx = 1'b0;
    if (err) begin
      check("err_expected", 32'(err_q.size() > 0), 32'd1);
      if (err_q.size() > 0) void'(err_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [N*DW-1:0] d;
    reset = 1'b1;
    req = '0;
    req_data = '0;
    tx_done = 1'b0;
    model_last = N - 1;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request from requester 2, done 10 cycles after start.
    d = 32'h1234_5678;
    d[2*DW +: DW] = 8'h41;
    txn(4'b0100, d, 9, 1'b0, 1'b0);

    // Timeout, then requester 1 is served.
    txn(4'b0001, 32'(d), TO, 1'b0, 1'b0);
    txn(4'b0010, 32'(d), 3, 1'b0, 1'b0);

    // tx_done coincides with the limit cycle.
    txn(4'b0001, 32'(d), TO - 1, 1'b0, 1'b0);

    // tx_done while idle changes nothing.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_start", 32'(start), 32'd0);
    @(negedge clk);
    check("idle_done_busy2", 32'(busy), 32'd0);

    // Data on slice 1 changes right after the grant.
    d = 32'hDEAD_BEEF;
    d[1*DW +: DW] = 8'h55;
    txn(4'b0010, d, 5, 1'b0, 1'b1);

    // All four requesting: strict rotation.
    for (int i = 0; i < 6; i++) begin
      rand_data();
      txn(4'b1111, req_data, 0, 1'b0, 1'b0);
    end

    // Reset during WAIT_DONE with requesters 0 and 1 holding req.
    rand_data();
    txn(4'b0001, req_data, 1, 1'b0, 1'b0);
    rand_data();
    issue(4'b0011, req_data, ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_start", 32'(start), 32'd0);
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      model_last = N - 1;
      push_exp(rr_model(4'b0011, model_last));
      model_last = 0;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_start_wait", 32'(start), 32'd1);
      finish(2, 1'b0, 1'b0);
    end

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int dl;
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      dl = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, TO - 1));
      rand_data();
      txn(m, req_data, dl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("grants_outstanding", 32'(exp_q.size()), 32'd0);
    check("errs_outstanding", 32'(err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
